// File: rtl/b_bus_arbiter.sv
// Round-robin arbiter for the shared B bus: grants one requester at a time, latches its
// source code into B_bus_ctrl and revokes long holds when someone else is waiting.
module b_bus_arbiter #(
  parameter int unsigned NREQ     = 3,
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     req,
  input  logic [4*NREQ-1:0]   req_sel,
  output logic [NREQ-1:0]     gnt,
  output logic [3:0]          B_bus_ctrl,
  output logic [NREQ-1:0]     sel_err,
  output logic                busy
);

  localparam int unsigned IdxW    = (NREQ > 2) ? 2 : 1;
  localparam logic [7:0]  MaxHold = 8'(MAX_HOLD);

  typedef enum logic [0:0] {StIdle, StGrant} state_e;

  state_e          state_q, state_d;
  logic [IdxW-1:0] owner_q, owner_d;
  logic [IdxW-1:0] ptr_q, ptr_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [NREQ-1:0] sel_err_q;
  logic [3:0]      sel_q, sel_d;
  logic [7:0]      hold_q, hold_d;

  logic [NREQ-1:0] code_ok;
  logic [NREQ-1:0] elig_other;
  logic            pick_found;
  logic [IdxW-1:0] pick_idx;
  logic [3:0]      pick_code;
  logic            do_grant;
  logic            do_idle;

  always_comb begin
    code_ok = '0;
    for (int i = 0; i < NREQ; i++) begin
      code_ok[i] = (req_sel[4*i +: 4] != 4'h0) && (req_sel[4*i +: 4] <= 4'h9);
    end
  end

  // The current owner is never a candidate, so a forced revocation always moves on.
  assign elig_other = req & code_ok & ~gnt_q;

  always_comb begin : p_pick
    int unsigned idx;
    idx        = 0;
    pick_found = 1'b0;
    pick_idx   = '0;
    pick_code  = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (32'(ptr_q) + 32'(k)) % NREQ;
      if (!pick_found && elig_other[idx]) begin
        pick_found = 1'b1;
        pick_idx   = IdxW'(idx);
        pick_code  = req_sel[4*idx +: 4];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    ptr_d    = ptr_q;
    gnt_d    = gnt_q;
    sel_d    = sel_q;
    hold_d   = hold_q;
    do_grant = 1'b0;
    do_idle  = 1'b0;

    unique case (state_q)
      StIdle: do_grant = pick_found;
      StGrant: begin
        if (!req[owner_q]) begin
          do_grant = pick_found;
          do_idle  = !pick_found;
        end else if ((MAX_HOLD != 0) && (hold_q >= MaxHold) && pick_found) begin
          do_grant = 1'b1;
        end else if (hold_q != 8'hff) begin
          hold_d = hold_q + 8'd1;
        end
      end
    endcase

    if (do_grant) begin
      state_d         = StGrant;
      owner_d         = pick_idx;
      gnt_d           = '0;
      gnt_d[pick_idx] = 1'b1;
      sel_d           = pick_code;
      hold_d          = 8'd1;
      ptr_d           = (32'(pick_idx) + 1 == NREQ) ? '0 : pick_idx + IdxW'(1);
    end else if (do_idle) begin
      state_d = StIdle;
      gnt_d   = '0;
      sel_d   = 4'h0;
      hold_d  = 8'd0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      owner_q   <= '0;
      ptr_q     <= '0;
      gnt_q     <= '0;
      sel_q     <= 4'h0;
      hold_q    <= 8'd0;
      sel_err_q <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      ptr_q     <= ptr_d;
      gnt_q     <= gnt_d;
      sel_q     <= sel_d;
      hold_q    <= hold_d;
      sel_err_q <= req & ~code_ok;
    end
  end

  assign gnt        = gnt_q;
  assign B_bus_ctrl = sel_q;
  assign sel_err    = sel_err_q;
  assign busy       = (state_q == StGrant);

endmodule

// File: tb/tb_b_bus_arbiter.sv
// Bench for b_bus_arbiter: directed scenarios with literal expectations plus random traffic,
// all compared every cycle against an index-level behavioural model of the arbiter.
module tb_b_bus_arbiter;
  localparam int NREQ = 3;
  localparam int MAXH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  req = '0;
  logic [11:0] req_sel = '0;
  logic [2:0]  gnt;
  logic [2:0]  sel_err;
  logic [3:0]  B_bus_ctrl;
  logic        busy;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Model state: owner index (-1 when idle), rotation start, hold length, latched code.
  int         m_owner = -1;
  int         m_ptr = 0;
  int         m_hold = 0;
  int         m_code = 0;
  logic [2:0] m_selerr = '0;

  b_bus_arbiter #(
    .NREQ     (NREQ),
    .MAX_HOLD (MAXH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .req_sel    (req_sel),
    .gnt        (gnt),
    .B_bus_ctrl (B_bus_ctrl),
    .sel_err    (sel_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int code_of(input int i);
    return int'(req_sel[4*i +: 4]);
  endfunction

  function automatic bit eligible(input int i);
    return req[i] && code_of(i) >= 1 && code_of(i) <= 9;
  endfunction

  task automatic model_reset();
    m_owner  = -1;
    m_ptr    = 0;
    m_hold   = 0;
    m_code   = 0;
    m_selerr = '0;
  endtask

  task automatic model_step();
    int pick;
    bit releasing;
    bit expired;
    pick = -1;
    for (int k = 0; k < NREQ; k++) begin
      int i;
      i = (m_ptr + k) % NREQ;
      if (pick < 0 && i != m_owner && eligible(i)) pick = i;
    end
    for (int i = 0; i < NREQ; i++) m_selerr[i] = req[i] && !(code_of(i) >= 1 && code_of(i) <= 9);
    releasing = (m_owner >= 0) && !req[m_owner];
    expired   = (m_owner >= 0) && (MAXH != 0) && (m_hold >= MAXH);
    if (pick >= 0 && (m_owner < 0 || releasing || expired)) begin
      m_owner = pick;
      m_code  = code_of(pick);
      m_hold  = 1;
      m_ptr   = (pick + 1) % NREQ;
    end else if (releasing) begin
      m_owner = -1;
      m_code  = 0;
      m_hold  = 0;
    end else if (m_owner >= 0) begin
      m_hold = (m_hold < 255) ? m_hold + 1 : 255;
    end
  endtask

  always @(negedge clk) begin
    if (chk_en && !rst) begin
      compare("gnt", 32'(gnt), (m_owner < 0) ? 32'd0 : 32'(1 << m_owner));
      compare("bctrl", 32'(B_bus_ctrl), (m_owner < 0) ? 32'd0 : 32'(m_code));
      compare("sel_err", 32'(sel_err), 32'(m_selerr));
      compare("busy", 32'(busy), 32'(m_owner >= 0));
    end
  end

  task automatic cyc();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic set_sel(input int i, input logic [3:0] c);
    req_sel[4*i +: 4] = c;
  endtask

  // Called at a falling edge: asserts reset between edges and checks the immediate clear.
  task automatic async_reset();
    #2;
    rst = 1'b1;
    #1;
    compare("rst_gnt", 32'(gnt), 32'd0);
    compare("rst_bctrl", 32'(B_bus_ctrl), 32'd0);
    compare("rst_busy", 32'(busy), 32'd0);
    model_reset();
    @(negedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    int n;
    int prev;
    int ord[4];
    int codes[3];
    ord   = '{0, 1, 2, 0};
    codes = '{1, 4, 9};

    repeat (2) @(negedge clk);
    compare("reset_gnt", 32'(gnt), 32'd0);
    compare("reset_bctrl", 32'(B_bus_ctrl), 32'd0);
    compare("reset_sel_err", 32'(sel_err), 32'd0);
    compare("reset_busy", 32'(busy), 32'd0);
    #1;
    rst = 1'b0;
    model_reset();
    chk_en = 1'b1;

    // Single requester
    req = 3'b010;
    set_sel(1, 4'h5);
    cyc();
    compare("single_gnt", 32'(gnt), 32'b010);
    compare("single_bctrl", 32'(B_bus_ctrl), 32'h5);
    repeat (4) cyc();
    req = 3'b000;
    cyc();
    compare("single_rel_gnt", 32'(gnt), 32'd0);
    compare("single_rel_bctrl", 32'(B_bus_ctrl), 32'd0);

    // Latched select
    req = 3'b001;
    set_sel(0, 4'h6);
    cyc();
    compare("latch_bctrl", 32'(B_bus_ctrl), 32'h6);
    set_sel(0, 4'h8);
    repeat (3) begin
      cyc();
      compare("latch_hold", 32'(B_bus_ctrl), 32'h6);
    end
    req = 3'b000;
    cyc();
    compare("latch_rel", 32'(B_bus_ctrl), 32'h0);

    // Invalid code on requester 0
    set_sel(0, 4'hC);
    set_sel(2, 4'h3);
    req = 3'b101;
    cyc();
    compare("inv_sel_err", 32'(sel_err), 32'b001);
    compare("inv_gnt", 32'(gnt), 32'b100);
    compare("inv_bctrl", 32'(B_bus_ctrl), 32'h3);
    repeat (5) cyc();
    compare("inv_hold_gnt", 32'(gnt), 32'b100);
    req = 3'b000;
    cyc();
    compare("inv_clear", 32'(sel_err), 32'd0);

    // Forced revocation after MAXH cycles
    set_sel(0, 4'h1);
    set_sel(1, 4'h4);
    req = 3'b001;
    cyc();
    req = 3'b011;
    n = 1;
    while (gnt == 3'b001 && n < 20) begin
      cyc();
      if (gnt == 3'b001) n++;
    end
    compare("revoke_len", 32'(n), 32'd4);
    compare("revoke_gnt", 32'(gnt), 32'b010);
    req = 3'b000;
    cyc();

    // No contender: owner keeps the bus
    req = 3'b001;
    n = 0;
    repeat (25) begin
      cyc();
      if (gnt == 3'b001) n++;
    end
    compare("persist_len", 32'(n), 32'd25);
    req = 3'b000;
    cyc();

    // Async reset mid-grant, then round-robin from index 0
    set_sel(1, 4'h7);
    req = 3'b010;
    cyc();
    cyc();
    async_reset();
    set_sel(0, 4'h1);
    set_sel(1, 4'h4);
    set_sel(2, 4'h9);
    req  = 3'b111;
    prev = -1;
    for (int k = 0; k < 4; k++) begin
      cyc();
      if (prev >= 0) req[prev] = 1'b1;
      compare("rr_gnt", 32'(gnt), 32'(1 << ord[k]));
      compare("rr_bctrl", 32'(B_bus_ctrl), 32'(codes[ord[k]]));
      cyc();
      compare("rr_gnt_hold", 32'(gnt), 32'(1 << ord[k]));
      req[ord[k]] = 1'b0;
      prev = ord[k];
    end
    req = 3'b000;
    cyc();

    // Random traffic
    for (int t = 0; t < 600; t++) begin
      for (int i = 0; i < NREQ; i++) begin
        if ($urandom_range(0, 3) == 0) req[i] = ~req[i];
        if ($urandom_range(0, 7) == 0) set_sel(i, 4'($urandom_range(0, 11)));
      end
      if ($urandom_range(0, 149) == 0) async_reset();
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/b_bus_arbiter.md
# b_bus_arbiter

Round-robin arbiter and sequencer for the shared 24-bit B bus of the downsampling processor. Up to NREQ requesters (microcode execute path, address generator, output writer) each ask for one B-bus source by its 4-bit source code. The block grants one at a time and drives the registered `B_bus_ctrl` select into the B-bus source decoder. It also enforces a maximum hold time so that no requester starves the others.

## Interface
- NREQ, 3: number of requesters, legal range 2..4.
- MAX_HOLD, 16: maximum grant length in cycles while another valid request waits. 0 disables forced revocation. Legal range 0..255.
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req  in  NREQ  per-requester request level. Held high for as long as the bus is needed.
- req_sel  in  4*NREQ  source code for requester i at [4i+3:4i]. Valid codes: 0001 MDR, 0010 PC, 0011 MBRU, 0100 L, 0101 C1, 0110 C2, 0111 C3, 1000 T, 1001 E.
- gnt  out  NREQ  one-hot grant, registered.
- B_bus_ctrl  out  4  registered source select to the B-bus decoder. 0000 means the bus is driven to zero.
- sel_err  out  NREQ  registered flag: requester i is requesting with an invalid code.
- busy  out  1  registered; equals OR of `gnt`.

## Operation
- State: `owner` (index), `gnt`, `ptr` (round-robin start index), `hold_cnt` (8 bit), `sel_q` (latched code).
- Eligibility: requester i is eligible when req[i]=1 and req_sel[i] is in 0001..1001. Codes 0000 and 1010..1111 make it ineligible.
- sel_err[i] is set on every cycle that req[i]=1 with an invalid code, and is 0 otherwise.
- Round-robin pick: first eligible index scanning ptr, ptr+1, …, wrapping modulo NREQ.
- Idle (gnt=0):
  - If any requester is eligible, grant the pick at the next edge.
  - On that edge: gnt=onehot(pick), B_bus_ctrl=req_sel[pick], hold_cnt=1, ptr=(pick+1) mod NREQ.
- Granted, owner keeps req high:
  - The grant holds and B_bus_ctrl stays at the code latched at grant time. Changes to req_sel[owner] during the grant are ignored.
  - hold_cnt increments and saturates at 255.
- Release (req[owner]=0):
  - If another requester is eligible, hand over directly at the next edge: no dead cycle, same update as a fresh grant.
  - Otherwise gnt=0, B_bus_ctrl=0000, hold_cnt=0.
- Forced revocation: when MAX_HOLD≠0, hold_cnt ≥ MAX_HOLD, and another requester is eligible, hand over at the next edge even though req[owner]=1.
  - The revoked requester stays eligible only in later rotation, because ptr has already passed it.
  - If no other requester is eligible, the owner keeps the bus indefinitely.
- Simultaneous requests: resolved purely by ptr order. After reset, ptr=0, so index 0 wins first.
- A requester that drops req in the same cycle it would be picked is not granted, because the pick uses current-cycle req.
- rst asserted mid-grant: all outputs clear immediately (asynchronously). No partial transfer is remembered.

## Timing
- Reset values: gnt=0, B_bus_ctrl=0000, sel_err=0, busy=0, ptr=0, hold_cnt=0.
- Grant latency: 1 cycle. A request sampled at edge n produces gnt/B_bus_ctrl valid after edge n+1.
- The B-bus data is valid in the same cycle as gnt, after the combinational decoder delay. The requester captures it at the following edge.
- Release latency: 1 cycle. With a waiting requester, the next owner's code appears exactly 1 cycle after the owner drops req.
- Forced revocation takes effect on the edge after hold_cnt reaches MAX_HOLD. The owner therefore holds the bus for exactly MAX_HOLD cycles.
- gnt and B_bus_ctrl always change on the same edge. B_bus_ctrl is never nonzero while gnt=0.

## Test plan
- Single requester: req[1]=1, sel=0101 at edge 0. After edge 1, gnt=010, B_bus_ctrl=0101. Drop req at edge 5; after edge 6, gnt=000, B_bus_ctrl=0000.
- Contention and round-robin:
  - req=111 with sels 0001/0100/1001, each released after 2 cycles of grant and then re-raised.
  - Required grant order: 0, 1, 2, 0. B_bus_ctrl sequence: 0001, 0100, 1001, 0001, with no dead cycles between owners.
- Invalid code:
  - req[0]=1, sel=1100 and req[2]=1, sel=0011.
  - Required: sel_err=001, gnt=100, B_bus_ctrl=0011. Requester 0 is never granted while its code is invalid.
- Forced revocation with MAX_HOLD=4:
  - req[0] held high, req[1] raised 1 cycle after grant0.
  - Required: gnt0 lasts exactly 4 cycles, then gnt=010. With req[1] never raised, gnt0 persists for more than 20 cycles.
- Latched select: change req_sel[owner] from 0110 to 1000 mid-grant. B_bus_ctrl must stay 0110 until release.
- Async reset: assert rst between edges during a grant. gnt, B_bus_ctrl and busy must go to 0 before the next edge. After release, requester 0 wins a simultaneous req=111.
